// File: rtl/vga_pkg.sv
// Shared VGA definitions: screen geometry and coordinate widths per resolution, default colour depth, engine states.
package vga_pkg;

  localparam logic [55:0] RES_320X240  = "320x240";
  localparam logic [55:0] RES_640X480  = "640x480";
  localparam int          COLOUR_W_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int res_xw(input logic [55:0] res);
    return (res == RES_640X480) ? 10 : 9;
  endfunction

  function automatic int res_yw(input logic [55:0] res);
    return (res == RES_640X480) ? 9 : 8;
  endfunction

  function automatic int res_width(input logic [55:0] res);
    return (res == RES_640X480) ? 640 : 320;
  endfunction

  function automatic int res_height(input logic [55:0] res);
    return (res == RES_640X480) ? 480 : 240;
  endfunction

endpackage

// File: rtl/vga_rect_filler_if.sv
// Request and pixel-write bus between a drawing FSM (master) and the rectangle fill engine (slave).
interface vga_rect_filler_if #(
  parameter int XW       = vga_pkg::res_xw(vga_pkg::RES_320X240),
  parameter int YW       = vga_pkg::res_yw(vga_pkg::RES_320X240),
  parameter int COLOUR_W = vga_pkg::COLOUR_W_DEF
);

  logic                req_valid;
  logic                req_ready;
  logic [XW-1:0]       req_x0;
  logic [YW-1:0]       req_y0;
  logic [XW-1:0]       req_w;
  logic [YW-1:0]       req_h;
  logic [COLOUR_W-1:0] req_colour;
  logic                pause;
  logic [XW-1:0]       x;
  logic [YW-1:0]       y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;
  logic                done;

  modport master (
    output req_valid, req_x0, req_y0, req_w, req_h, req_colour, pause,
    input  req_ready, x, y, colour, plot, done
  );

  modport slave (
    input  req_valid, req_x0, req_y0, req_w, req_h, req_colour, pause,
    output req_ready, x, y, colour, plot, done
  );

endinterface

// File: rtl/vga_rect_clip.sv
// Accept-time extent computation; with RECT_CLIP_EN the rectangle is clipped to the screen, otherwise passed through.
// Purely combinational, no backpressure.
module vga_rect_clip
  import vga_pkg::*;
#(
  parameter logic [55:0] RESOLUTION = RES_320X240,
  localparam int         XW         = res_xw(RESOLUTION),
  localparam int         YW         = res_yw(RESOLUTION)
) (
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  output logic [XW-1:0] x0_eff,
  output logic [YW-1:0] y0_eff,
  output logic [XW-1:0] w_eff,
  output logic [YW-1:0] h_eff,
  output logic          empty
);

  assign x0_eff = x0;
  assign y0_eff = y0;

`ifdef RECT_CLIP_EN
  localparam logic [XW-1:0] WIDTH  = XW'(res_width(RESOLUTION));
  localparam logic [YW-1:0] HEIGHT = YW'(res_height(RESOLUTION));

  logic          x_off;
  logic          y_off;
  logic [XW-1:0] x_room;
  logic [YW-1:0] y_room;

  // Room is only meaningful when the origin is on screen; the off flags mask the wrapped case.
  assign x_off  = (x0 >= WIDTH);
  assign y_off  = (y0 >= HEIGHT);
  assign x_room = WIDTH - x0;
  assign y_room = HEIGHT - y0;
  assign w_eff  = x_off ? '0 : ((w < x_room) ? w : x_room);
  assign h_eff  = y_off ? '0 : ((h < y_room) ? h : y_room);
`else
  assign w_eff = w;
  assign h_eff = h;
`endif

  assign empty = (w_eff == '0) || (h_eff == '0);

endmodule

// File: rtl/vga_rect_filler.sv
// Rectangle fill engine: one pixel per cycle in raster order from the cycle after accept, done pulse one cycle after the last pixel.
// req_ready only in IDLE; pause freezes the raster and drops plot. Optional screen clipping via RECT_CLIP_EN.
module vga_rect_filler
  import vga_pkg::*;
#(
  parameter logic [55:0] RESOLUTION = RES_320X240,
  parameter int          COLOUR_W   = COLOUR_W_DEF,
  localparam int         XW         = res_xw(RESOLUTION),
  localparam int         YW         = res_yw(RESOLUTION)
) (
  input logic              clock,
  input logic              reset,
  vga_rect_filler_if.slave bus
);

  state_t state_q, state_d;

  logic [XW-1:0]       x0_q, x0_d;
  logic [YW-1:0]       y0_q, y0_d;
  logic [XW-1:0]       w_q, w_d;
  logic [YW-1:0]       h_q, h_d;
  logic [XW-1:0]       cx_q, cx_d;
  logic [YW-1:0]       cy_q, cy_d;
  logic                fin_q, fin_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                plot_q, plot_d;
  logic                done_q, done_d;

  logic [XW-1:0] x0_eff, w_eff;
  logic [YW-1:0] y0_eff, h_eff;
  logic          empty;
  logic          accept;
  logic          last_col;

  vga_rect_clip #(
    .RESOLUTION (RESOLUTION)
  ) u_clip (
    .x0     (bus.req_x0),
    .y0     (bus.req_y0),
    .w      (bus.req_w),
    .h      (bus.req_h),
    .x0_eff (x0_eff),
    .y0_eff (y0_eff),
    .w_eff  (w_eff),
    .h_eff  (h_eff),
    .empty  (empty)
  );

  assign accept        = (state_q == IDLE) && bus.req_valid;
  assign last_col      = (cx_q == w_q - XW'(1));
  assign bus.req_ready = (state_q == IDLE);
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.colour    = colour_q;
  assign bus.plot      = plot_q;
  assign bus.done      = done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = empty ? DONE : DRAW;
      DRAW:    if (fin_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cx/cy always point at the next pixel still to be emitted; fin marks that the last one is already out.
  always_comb begin
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    fin_d    = fin_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          x0_d = x0_eff;
          y0_d = y0_eff;
          w_d  = w_eff;
          h_d  = h_eff;
          if (empty) begin
            done_d = 1'b1;
            fin_d  = 1'b0;
          end else begin
            x_d      = x0_eff;
            y_d      = y0_eff;
            colour_d = bus.req_colour;
            plot_d   = 1'b1;
            fin_d    = (w_eff == XW'(1)) && (h_eff == YW'(1));
            if (w_eff == XW'(1)) begin
              cx_d = '0;
              cy_d = YW'(1);
            end else begin
              cx_d = XW'(1);
              cy_d = '0;
            end
          end
        end
      end
      DRAW: begin
        if (fin_q) begin
          done_d = 1'b1;
        end else if (!bus.pause) begin
          x_d    = x0_q + cx_q;
          y_d    = y0_q + cy_q;
          plot_d = 1'b1;
          fin_d  = last_col && (cy_q == h_q - YW'(1));
          if (last_col) begin
            cx_d = '0;
            cy_d = cy_q + YW'(1);
          end else begin
            cx_d = cx_q + XW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      fin_q    <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      fin_q    <= fin_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Scoreboard bench for vga_rect_filler (320x240): directed rectangles with hand-computed pixels and cycle stamps.
module tb_vga_rect_filler;

  localparam int XW = 9;
  localparam int YW = 8;
  localparam int CW = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vga_rect_filler_if #(.XW(XW), .YW(YW), .COLOUR_W(CW)) bus ();

  vga_rect_filler #(
    .RESOLUTION ("320x240"),
    .COLOUR_W   (CW)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit is_done;
    int x;
    int y;
    int c;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc         = 0;
  int   vectors     = 0;
  int   miscompares = 0;
  bit   mon_en      = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void exp_pix(input int x, input int y, input int c, input int e);
    exp_t t;
    t.is_done = 1'b0; t.x = x; t.y = y; t.c = c; t.cyc = e;
    exp_q.push_back(t);
  endfunction

  function automatic void exp_done(input int e);
    exp_t t;
    t.is_done = 1'b1; t.x = 0; t.y = 0; t.c = 0; t.cyc = e;
    exp_q.push_back(t);
  endfunction

  function automatic void mon_pop(input bit is_done);
    exp_t e;
    int   ax, ay, ac;
    ax = int'(bus.x);
    ay = int'(bus.y);
    ac = int'(bus.colour);
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got (%0d,%0d) c=%0d at cycle %0d, expected no output",
               is_done ? "done" : "plot", ax, ay, ac, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.is_done != is_done || e.cyc != cyc ||
          (!is_done && (e.x != ax || e.y != ay || e.c != ac))) begin
        miscompares++;
        $display("FAIL scoreboard: got %s (%0d,%0d) c=%0d at cycle %0d, expected %s (%0d,%0d) c=%0d at cycle %0d",
                 is_done ? "done" : "plot", ax, ay, ac, cyc,
                 e.is_done ? "done" : "plot", e.x, e.y, e.c, e.cyc);
      end
    end
  endfunction

  always @(negedge clock) begin
    if (mon_en && !reset) begin
      if (bus.plot) mon_pop(1'b0);
      if (bus.done) mon_pop(1'b1);
    end
  end

  // Returns at the negedge before the accepting edge, so expectations can be queued in time.
  task automatic start_req(input int x0, input int y0, input int w, input int h, input int c,
                           output int acc);
    @(negedge clock);
    bus.req_x0     = XW'(x0);
    bus.req_y0     = YW'(y0);
    bus.req_w      = XW'(w);
    bus.req_h      = YW'(h);
    bus.req_colour = CW'(c);
    bus.req_valid  = 1'b1;
    acc = -1;
    for (int n = 0; n < 60; n++) begin
      if (bus.req_ready) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clock);
    end
    if (acc < 0) check("req_accept_timeout", 0, 1);
  endtask

  task automatic end_req();
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge clock);
    check("drain_queue_empty", exp_q.size(), 0);
    repeat (2) @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, e2;
    bus.req_valid  = 1'b0;
    bus.req_x0     = '0;
    bus.req_y0     = '0;
    bus.req_w      = '0;
    bus.req_h      = '0;
    bus.req_colour = '0;
    bus.pause      = 1'b0;

    repeat (2) @(negedge clock);
    check("rst_ready",  bus.req_ready, 1);
    check("rst_plot",   bus.plot,      0);
    check("rst_done",   bus.done,      0);
    check("rst_x",      bus.x,         0);
    check("rst_y",      bus.y,         0);
    check("rst_colour", bus.colour,    0);
    reset = 1'b0;

    // 3x2 raster
    start_req(10, 20, 3, 2, 5, e);
    exp_pix(10, 20, 5, e);     exp_pix(11, 20, 5, e + 1); exp_pix(12, 20, 5, e + 2);
    exp_pix(10, 21, 5, e + 3); exp_pix(11, 21, 5, e + 4); exp_pix(12, 21, 5, e + 5);
    exp_done(e + 6);
    end_req();
    drain();

    // empty rectangles
    start_req(5, 5, 0, 4, 2, e);
    exp_done(e);
    end_req();
    drain();
    start_req(5, 5, 4, 0, 2, e);
    exp_done(e);
    end_req();
    drain();

    // single pixel
    start_req(0, 0, 1, 1, 7, e);
    exp_pix(0, 0, 7, e);
    exp_done(e + 1);
    end_req();
    drain();

    // pause for 3 cycles after the second pixel of a 4x1
    start_req(100, 50, 4, 1, 3, e);
    exp_pix(100, 50, 3, e);     exp_pix(101, 50, 3, e + 1);
    exp_pix(102, 50, 3, e + 5); exp_pix(103, 50, 3, e + 6);
    exp_done(e + 7);
    end_req();
    @(negedge clock);
    bus.pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      check("pause_plot", bus.plot, 0);
      check("pause_x",    bus.x,    101);
      check("pause_y",    bus.y,    50);
    end
    bus.pause = 1'b0;
    drain();

    // request held while busy is taken only once the engine is idle again
    start_req(0, 0, 4, 1, 1, e);
    exp_pix(0, 0, 1, e); exp_pix(1, 0, 1, e + 1); exp_pix(2, 0, 1, e + 2); exp_pix(3, 0, 1, e + 3);
    exp_done(e + 4);
    end_req();
    @(negedge clock);
    check("busy_ready", bus.req_ready, 0);
    start_req(200, 100, 2, 1, 6, e2);
    check("busy_accept_cycle", e2, e + 6);
    exp_pix(200, 100, 6, e2); exp_pix(201, 100, 6, e2 + 1);
    exp_done(e2 + 2);
    end_req();
    drain();

`ifdef RECT_CLIP_EN
    start_req(318, 239, 5, 4, 7, e);
    exp_pix(318, 239, 7, e); exp_pix(319, 239, 7, e + 1);
    exp_done(e + 2);
    end_req();
    drain();
    start_req(320, 10, 4, 4, 7, e);
    exp_done(e);
    end_req();
    drain();
`endif

    // reset in the middle of an 8x8
    start_req(30, 40, 8, 8, 4, e);
    mon_en = 1'b0;
    end_req();
    repeat (9) @(negedge clock);
    check("middraw_plot_active", bus.plot, 1);
    reset = 1'b1;
    @(negedge clock);
    check("mrst_plot",  bus.plot,      0);
    check("mrst_done",  bus.done,      0);
    check("mrst_ready", bus.req_ready, 1);
    check("mrst_x",     bus.x,         0);
    check("mrst_y",     bus.y,         0);
    reset  = 1'b0;
    mon_en = 1'b1;
    start_req(2, 3, 2, 2, 1, e);
    exp_pix(2, 3, 1, e);     exp_pix(3, 3, 1, e + 1);
    exp_pix(2, 4, 1, e + 2); exp_pix(3, 4, 1, e + 3);
    exp_done(e + 4);
    end_req();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
